sargantana_icache_refill_ctrl: RTL and testbench
================================================

SARGANTANA_ICACHE_REFILL_CTRL -- requirements
Module: sargantana_icache_refill_ctrl

Interface
REQ-001 The block SHALL have the parameter ICACHE_N_WAY, default 4: number of ways, a power of two of at least 2.
REQ-002 The block SHALL have the parameter ICACHE_IDX_WIDTH, default 6: set-index width.
REQ-003 The block SHALL have the parameter ICACHE_LINE_WIDTH, default 128: refill line width in bits.
REQ-004 The block SHALL have the port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have the port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the port flush_i, input, 1 bit: kills any in-flight refill.
REQ-007 The block SHALL have these miss-handshake ports:
- miss_valid_i, input, 1 bit: miss request.
- miss_ready_o, output, 1 bit: controller ready for a miss.
- miss_idx_i, input, ICACHE_IDX_WIDTH: set index of the miss.
REQ-008 The block SHALL have the port way_valid_i, input, ICACHE_N_WAY bits: valid bits of the indexed set, sampled on accept.
REQ-009 The block SHALL have these LFSR ports:
- lfsr_way_i, input, $clog2(ICACHE_N_WAY) bits: pseudo-random way from the LFSR.
- lfsr_en_o, output, 1 bit: advance-LFSR pulse.
REQ-010 The block SHALL have these memory ports:
- mem_req_valid_o, output, 1 bit; mem_req_ready_i, input, 1 bit: line-fetch request handshake.
- mem_req_idx_o, output, ICACHE_IDX_WIDTH: index of the fetched line.
- mem_resp_valid_i, input, 1 bit; mem_resp_data_i, input, ICACHE_LINE_WIDTH; mem_resp_err_i, input, 1 bit: response.
REQ-011 The block SHALL have these refill-write ports:
- refill_we_o, output, 1 bit: write strobe.
- refill_way_o, output, $clog2(ICACHE_N_WAY): target way.
- refill_idx_o, output, ICACHE_IDX_WIDTH: target set.
- refill_data_o, output, ICACHE_LINE_WIDTH: line data.
REQ-012 The block SHALL have the status ports refill_done_o (output, 1 bit) and refill_err_o (output, 1 bit): one-cycle completion and error pulses.

Function
REQ-013 The block SHALL implement the FSM states IDLE, REQ, WAIT and WRITE.
REQ-014 In IDLE, miss_ready_o SHALL be 1; in all other states it SHALL be 0.
REQ-015 A miss SHALL be accepted in IDLE on miss_valid_i&miss_ready_o; the block SHALL then latch the index and the victim way and go to REQ.
REQ-016 In REQ, mem_req_valid_o SHALL be 1 and mem_req_idx_o SHALL be stable until mem_req_ready_i; then the FSM SHALL go to WAIT.
REQ-017 In WAIT, on mem_resp_valid_i with mem_resp_err_i=0, the block SHALL latch the data and go to WRITE.
REQ-018 In WAIT, on mem_resp_valid_i with mem_resp_err_i=1, the block SHALL pulse refill_err_o, perform no write, and go to IDLE.
REQ-019 WRITE SHALL last exactly one cycle with refill_we_o=1 and refill_done_o=1, then go to IDLE.
REQ-020 Latency: accept at cycle T gives mem_req_valid_o at T+1; a good response at cycle R gives refill_we_o at R+1.
REQ-021 lfsr_en_o SHALL pulse for exactly the accept cycle, and only when the victim came from lfsr_way_i.
REQ-022 flush_i in IDLE SHALL have no effect.
REQ-023 flush_i in REQ SHALL leave mem_req_valid_o asserted until the handshake completes, and SHALL set a kill flag.
REQ-024 flush_i in WAIT SHALL set the kill flag.
REQ-025 With the kill flag set, the response SHALL be consumed with no write, no done and no error pulse, and the FSM SHALL return to IDLE.
REQ-026 flush_i in WRITE SHALL suppress refill_we_o and refill_done_o in that cycle.
REQ-027 mem_resp_valid_i outside WAIT SHALL be ignored.
REQ-028 refill_way_o, refill_idx_o and refill_data_o SHALL hold their last values outside WRITE.

Reset
REQ-029 When rst_i=1 at a clock edge, the FSM SHALL go to IDLE and the kill flag and all latched registers SHALL clear to 0.
REQ-030 During and after reset, all outputs SHALL read 0 except miss_ready_o, which SHALL read 1 after reset.
REQ-031 Reset asserted mid-refill SHALL abandon the refill with no write and no pulse.

Configuration
REQ-032 With ICACHE_INVALID_FIRST_EN defined, the victim SHALL be the lowest-numbered way whose way_valid_i bit is 0; only if all ways are valid SHALL the victim be lfsr_way_i.
REQ-033 Without ICACHE_INVALID_FIRST_EN, way_valid_i SHALL be ignored and the victim SHALL always be lfsr_way_i, so lfsr_en_o pulses on every accept.

Structure
REQ-034 The refill_state_t enum and a localparam for the way-index width SHALL live in sargantana_icache_pkg.
REQ-035 Victim selection SHALL be the combinational sub-module sargantana_icache_victim_sel (inputs way_valid_i, lfsr_way_i; outputs way, used_lfsr).

Verification
REQ-036 Macro on, way_valid_i=4'b1011, lfsr_way_i=2 -> refill_way_o=2'd2, lfsr_en_o stays 0.
REQ-037 Macro on, way_valid_i=4'b1111, lfsr_way_i=1 -> refill_way_o=1, lfsr_en_o=1 in the accept cycle only.
REQ-038 Accept at T, mem_req_ready_i at T+3, response at T+6 -> refill_we_o and refill_done_o high only at T+7, then miss_ready_o=1 at T+8.
REQ-039 Response with mem_resp_err_i=1 -> refill_err_o for 1 cycle, refill_we_o stays 0, FSM back in IDLE.
REQ-040 flush_i in WAIT, then a good response -> no refill_we_o, no refill_done_o, IDLE next cycle.
REQ-041 rst_i pulsed in REQ -> mem_req_valid_o=0 the next cycle, miss_ready_o=1, no write.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// sargantana_icache_pkg: shared refill FSM state type and default way geometry for the icache
package sargantana_icache_pkg;
  localparam int unsigned DEFAULT_N_WAY = 4;
  localparam int unsigned WAY_IDX_W = $clog2(DEFAULT_N_WAY);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} refill_state_t;
endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// sargantana_icache_victim_sel: victim way choice; ICACHE_INVALID_FIRST_EN prefers the lowest invalid way over the LFSR
module sargantana_icache_victim_sel #(
  parameter int unsigned ICACHE_N_WAY = 4
) (
  input  logic [ICACHE_N_WAY-1:0]         way_valid_i,
  input  logic [$clog2(ICACHE_N_WAY)-1:0] lfsr_way_i,
  output logic [$clog2(ICACHE_N_WAY)-1:0] way,
  output logic                            used_lfsr
);
  localparam int unsigned WAY_W = $clog2(ICACHE_N_WAY);
`ifdef ICACHE_INVALID_FIRST_EN
  always_comb begin
    way = lfsr_way_i;
    used_lfsr = 1'b1;
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--)
      if (!way_valid_i[i]) begin
        way = WAY_W'(i);
        used_lfsr = 1'b0;
      end
  end
`else
  logic unused_way_valid;
  assign unused_way_valid = ^way_valid_i;
  assign way = lfsr_way_i;
  assign used_lfsr = 1'b1;
`endif
endmodule

// File: rtl/sargantana_icache_refill_ctrl.sv
// sargantana_icache_refill_ctrl: icache miss refill FSM (IDLE/REQ/WAIT/WRITE) with flush kill; victim policy via ICACHE_INVALID_FIRST_EN
module sargantana_icache_refill_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned ICACHE_N_WAY      = DEFAULT_N_WAY,
  parameter int unsigned ICACHE_IDX_WIDTH  = 6,
  parameter int unsigned ICACHE_LINE_WIDTH = 128
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            miss_valid_i,
  output logic                            miss_ready_o,
  input  logic [ICACHE_IDX_WIDTH-1:0]     miss_idx_i,
  input  logic [ICACHE_N_WAY-1:0]         way_valid_i,
  input  logic [$clog2(ICACHE_N_WAY)-1:0] lfsr_way_i,
  output logic                            lfsr_en_o,
  output logic                            mem_req_valid_o,
  input  logic                            mem_req_ready_i,
  output logic [ICACHE_IDX_WIDTH-1:0]     mem_req_idx_o,
  input  logic                            mem_resp_valid_i,
  input  logic [ICACHE_LINE_WIDTH-1:0]    mem_resp_data_i,
  input  logic                            mem_resp_err_i,
  output logic                            refill_we_o,
  output logic [$clog2(ICACHE_N_WAY)-1:0] refill_way_o,
  output logic [ICACHE_IDX_WIDTH-1:0]     refill_idx_o,
  output logic [ICACHE_LINE_WIDTH-1:0]    refill_data_o,
  output logic                            refill_done_o,
  output logic                            refill_err_o
);
  localparam int unsigned WAY_W = $clog2(ICACHE_N_WAY);
  refill_state_t state_q, state_d;
  logic kill_q, kill_d;
  logic [ICACHE_IDX_WIDTH-1:0] idx_q, ref_idx_q;
  logic [WAY_W-1:0] way_q, ref_way_q, victim;
  logic [ICACHE_LINE_WIDTH-1:0] data_q;
  logic used_lfsr, accept, resp_fire, killed, good;
  sargantana_icache_victim_sel #(.ICACHE_N_WAY(ICACHE_N_WAY)) u_victim_sel (
    .way_valid_i (way_valid_i),
    .lfsr_way_i  (lfsr_way_i),
    .way         (victim),
    .used_lfsr   (used_lfsr)
  );
  // every output is forced low while reset is held, so nothing leaks from an abandoned refill
  assign miss_ready_o    = !rst_i && state_q == IDLE;
  assign accept          = miss_valid_i && miss_ready_o;
  assign lfsr_en_o       = accept && used_lfsr;
  assign mem_req_valid_o = !rst_i && state_q == REQ;
  assign mem_req_idx_o   = mem_req_valid_o ? idx_q : '0;
  assign resp_fire       = !rst_i && state_q == WAIT && mem_resp_valid_i;
  assign killed          = kill_q || flush_i;
  assign refill_err_o    = resp_fire && mem_resp_err_i && !killed;
  assign good            = resp_fire && !mem_resp_err_i && !killed;
  assign refill_we_o     = !rst_i && state_q == WRITE && !flush_i;
  assign refill_done_o   = refill_we_o;
  assign refill_way_o    = rst_i ? '0 : ref_way_q;
  assign refill_idx_o    = rst_i ? '0 : ref_idx_q;
  assign refill_data_o   = rst_i ? '0 : data_q;
  always_comb begin
    state_d = state_q;
    kill_d = kill_q;
    case (state_q)
      IDLE: state_d = miss_valid_i ? REQ : IDLE;
      REQ: begin
        kill_d = kill_q || flush_i;
        state_d = mem_req_ready_i ? WAIT : REQ;
      end
      WAIT: begin
        kill_d = mem_resp_valid_i ? 1'b0 : killed;
        state_d = !mem_resp_valid_i ? WAIT : (killed || mem_resp_err_i) ? IDLE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      kill_q    <= 1'b0;
      idx_q     <= '0;
      way_q     <= '0;
      ref_idx_q <= '0;
      ref_way_q <= '0;
      data_q    <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (accept) begin
        idx_q <= miss_idx_i;
        way_q <= victim;
      end
      // the visible refill target only moves when a write is actually coming
      if (good) begin
        ref_idx_q <= idx_q;
        ref_way_q <= way_q;
        data_q    <= mem_resp_data_i;
      end
    end
  end
endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// tb_sargantana_icache_refill_ctrl: directed self-checking bench for the icache refill controller
module tb_sargantana_icache_refill_ctrl;
`ifdef ICACHE_INVALID_FIRST_EN
  localparam logic INV_FIRST = 1'b1;
`else
  localparam logic INV_FIRST = 1'b0;
`endif
  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 = {4{32'hA5A5_5A5A}};
  logic clk_i = 1'b0;
  logic rst_i, flush_i, miss_valid_i, miss_ready_o, lfsr_en_o;
  logic [5:0] miss_idx_i, mem_req_idx_o, refill_idx_o;
  logic [3:0] way_valid_i;
  logic [1:0] lfsr_way_i, refill_way_o;
  logic mem_req_valid_o, mem_req_ready_i, mem_resp_valid_i, mem_resp_err_i;
  logic [127:0] mem_resp_data_i, refill_data_o;
  logic refill_we_o, refill_done_o, refill_err_o;
  int checks = 0;
  int errors = 0;
  always #5 clk_i = ~clk_i;
  sargantana_icache_refill_ctrl #(.ICACHE_N_WAY(4), .ICACHE_IDX_WIDTH(6), .ICACHE_LINE_WIDTH(128)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_idx_i(miss_idx_i),
    .way_valid_i(way_valid_i), .lfsr_way_i(lfsr_way_i), .lfsr_en_o(lfsr_en_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_idx_o(mem_req_idx_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i),
    .refill_we_o(refill_we_o), .refill_way_o(refill_way_o), .refill_idx_o(refill_idx_o),
    .refill_data_o(refill_data_o), .refill_done_o(refill_done_o), .refill_err_o(refill_err_o)
  );
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    tick();
    #1;
    checks++; if (miss_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_during got %b exp 0", miss_ready_o); end
    checks++; if ({mem_req_valid_o, refill_we_o, refill_done_o, refill_err_o, lfsr_en_o} !== 5'b0) begin errors++; $display("FAIL rst_outs_during got %b exp 00000", {mem_req_valid_o, refill_we_o, refill_done_o, refill_err_o, lfsr_en_o}); end
    tick();
    rst_i = 1'b0;
    tick();
    #1;
    checks++; if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", miss_ready_o); end
    checks++; if ({mem_req_valid_o, mem_req_idx_o, refill_way_o, refill_idx_o} !== 15'b0) begin errors++; $display("FAIL rst_regs_after got %h exp 0", {mem_req_valid_o, mem_req_idx_o, refill_way_o, refill_idx_o}); end
    checks++; if (refill_data_o !== 128'b0) begin errors++; $display("FAIL rst_data_after got %h exp 0", refill_data_o); end
  endtask
  task automatic test_latency;
    miss_valid_i = 1'b1; miss_idx_i = 6'h2A; way_valid_i = 4'b1011; lfsr_way_i = 2'd2;
    #1;
    checks++; if (lfsr_en_o !== !INV_FIRST) begin errors++; $display("FAIL lat_lfsr_en got %b exp %b", lfsr_en_o, !INV_FIRST); end
    tick();
    miss_valid_i = 1'b0; way_valid_i = 4'b0;
    #1;
    checks++; if ({mem_req_valid_o, mem_req_idx_o} !== {1'b1, 6'h2A}) begin errors++; $display("FAIL lat_req_t1 got %h exp %h", {mem_req_valid_o, mem_req_idx_o}, {1'b1, 6'h2A}); end
    checks++; if ({miss_ready_o, lfsr_en_o} !== 2'b00) begin errors++; $display("FAIL lat_busy_t1 got %b exp 00", {miss_ready_o, lfsr_en_o}); end
    tick();
    mem_resp_valid_i = 1'b1; mem_resp_err_i = 1'b1;
    #1;
    checks++; if ({mem_req_valid_o, refill_err_o} !== 2'b10) begin errors++; $display("FAIL lat_resp_in_req got %b exp 10", {mem_req_valid_o, refill_err_o}); end
    tick();
    mem_resp_valid_i = 1'b0; mem_resp_err_i = 1'b0; mem_req_ready_i = 1'b1;
    #1;
    checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL lat_req_t3 got %b exp 1", mem_req_valid_o); end
    tick();
    mem_req_ready_i = 1'b0;
    #1;
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL lat_wait_t4 got %b exp 0", mem_req_valid_o); end
    tick();
    tick();
    mem_resp_valid_i = 1'b1; mem_resp_data_i = D1;
    #1;
    checks++; if (refill_we_o !== 1'b0) begin errors++; $display("FAIL lat_we_t6 got %b exp 0", refill_we_o); end
    tick();
    mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    #1;
    checks++; if ({refill_we_o, refill_done_o, refill_way_o, refill_idx_o} !== {1'b1, 1'b1, 2'd2, 6'h2A}) begin errors++; $display("FAIL lat_write_t7 got %h exp %h", {refill_we_o, refill_done_o, refill_way_o, refill_idx_o}, {1'b1, 1'b1, 2'd2, 6'h2A}); end
    checks++; if (refill_data_o !== D1) begin errors++; $display("FAIL lat_data_t7 got %h exp %h", refill_data_o, D1); end
    tick();
    #1;
    checks++; if ({refill_we_o, refill_done_o, miss_ready_o} !== 3'b001) begin errors++; $display("FAIL lat_idle_t8 got %b exp 001", {refill_we_o, refill_done_o, miss_ready_o}); end
    checks++; if (refill_data_o !== D1) begin errors++; $display("FAIL lat_data_hold got %h exp %h", refill_data_o, D1); end
  endtask
  task automatic test_lfsr_all_valid;
    miss_valid_i = 1'b1; miss_idx_i = 6'h05; way_valid_i = 4'b1111; lfsr_way_i = 2'd1;
    #1;
    checks++; if (lfsr_en_o !== 1'b1) begin errors++; $display("FAIL lfsr_en_accept got %b exp 1", lfsr_en_o); end
    tick();
    miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    #1;
    checks++; if ({lfsr_en_o, mem_req_valid_o} !== 2'b01) begin errors++; $display("FAIL lfsr_en_after got %b exp 01", {lfsr_en_o, mem_req_valid_o}); end
    tick();
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_data_i = D2;
    #1;
    checks++; if ({refill_way_o, refill_idx_o} !== {2'd2, 6'h2A}) begin errors++; $display("FAIL lfsr_hold_prev got %h exp %h", {refill_way_o, refill_idx_o}, {2'd2, 6'h2A}); end
    tick();
    mem_resp_valid_i = 1'b0;
    #1;
    checks++; if ({refill_we_o, refill_way_o, refill_idx_o} !== {1'b1, 2'd1, 6'h05}) begin errors++; $display("FAIL lfsr_write got %h exp %h", {refill_we_o, refill_way_o, refill_idx_o}, {1'b1, 2'd1, 6'h05}); end
    checks++; if (refill_data_o !== D2) begin errors++; $display("FAIL lfsr_data got %h exp %h", refill_data_o, D2); end
    tick();
  endtask
  task automatic test_error;
    miss_valid_i = 1'b1; miss_idx_i = 6'h11; lfsr_way_i = 2'd3;
    tick();
    miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_err_i = 1'b1; mem_resp_data_i = 128'hBAD;
    #1;
    checks++; if ({refill_err_o, refill_we_o} !== 2'b10) begin errors++; $display("FAIL err_pulse got %b exp 10", {refill_err_o, refill_we_o}); end
    tick();
    mem_resp_valid_i = 1'b0; mem_resp_err_i = 1'b0;
    #1;
    checks++; if ({refill_err_o, refill_we_o, refill_done_o, miss_ready_o} !== 4'b0001) begin errors++; $display("FAIL err_after got %b exp 0001", {refill_err_o, refill_we_o, refill_done_o, miss_ready_o}); end
    checks++; if (refill_data_o !== D2) begin errors++; $display("FAIL err_no_write got %h exp %h", refill_data_o, D2); end
  endtask
  task automatic test_flush_wait;
    miss_valid_i = 1'b1; miss_idx_i = 6'h3F; lfsr_way_i = 2'd0; flush_i = 1'b1;
    #1;
    checks++; if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL fw_idle_ready got %b exp 1", miss_ready_o); end
    tick();
    miss_valid_i = 1'b0; flush_i = 1'b0; mem_req_ready_i = 1'b1;
    #1;
    checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL fw_idle_flush_noeffect got %b exp 1", mem_req_valid_o); end
    tick();
    mem_req_ready_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_data_i = D1;
    #1;
    checks++; if ({refill_we_o, refill_err_o} !== 2'b00) begin errors++; $display("FAIL fw_resp got %b exp 00", {refill_we_o, refill_err_o}); end
    tick();
    mem_resp_valid_i = 1'b0;
    #1;
    checks++; if ({refill_we_o, refill_done_o, miss_ready_o} !== 3'b001) begin errors++; $display("FAIL fw_after got %b exp 001", {refill_we_o, refill_done_o, miss_ready_o}); end
    checks++; if ({refill_data_o, refill_idx_o} !== {D2, 6'h05}) begin errors++; $display("FAIL fw_hold got %h exp %h", {refill_data_o, refill_idx_o}, {D2, 6'h05}); end
  endtask
  task automatic test_flush_req_write;
    miss_valid_i = 1'b1; miss_idx_i = 6'h0C; lfsr_way_i = 2'd2;
    tick();
    miss_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL fr_req_flush got %b exp 1", mem_req_valid_o); end
    tick();
    flush_i = 1'b0; mem_req_ready_i = 1'b1;
    #1;
    checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL fr_req_hold got %b exp 1", mem_req_valid_o); end
    tick();
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_err_i = 1'b1;
    #1;
    checks++; if ({refill_err_o, refill_we_o} !== 2'b00) begin errors++; $display("FAIL fr_killed_err got %b exp 00", {refill_err_o, refill_we_o}); end
    tick();
    mem_resp_valid_i = 1'b0; mem_resp_err_i = 1'b0;
    #1;
    checks++; if ({miss_ready_o, refill_done_o} !== 2'b10) begin errors++; $display("FAIL fr_idle got %b exp 10", {miss_ready_o, refill_done_o}); end
    miss_valid_i = 1'b1; miss_idx_i = 6'h21; lfsr_way_i = 2'd3;
    tick();
    miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_data_i = D1;
    tick();
    mem_resp_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    checks++; if ({refill_we_o, refill_done_o} !== 2'b00) begin errors++; $display("FAIL fwr_suppress got %b exp 00", {refill_we_o, refill_done_o}); end
    tick();
    flush_i = 1'b0;
    #1;
    checks++; if ({miss_ready_o, refill_we_o} !== 2'b10) begin errors++; $display("FAIL fwr_idle got %b exp 10", {miss_ready_o, refill_we_o}); end
  endtask
  task automatic test_reset_mid;
    miss_valid_i = 1'b1; miss_idx_i = 6'h15; lfsr_way_i = 2'd1;
    tick();
    miss_valid_i = 1'b0; rst_i = 1'b1;
    #1;
    checks++; if ({mem_req_valid_o, miss_ready_o} !== 2'b00) begin errors++; $display("FAIL rm_during got %b exp 00", {mem_req_valid_o, miss_ready_o}); end
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if ({mem_req_valid_o, miss_ready_o, refill_we_o} !== 3'b010) begin errors++; $display("FAIL rm_after got %b exp 010", {mem_req_valid_o, miss_ready_o, refill_we_o}); end
    checks++; if ({refill_way_o, refill_idx_o, refill_data_o} !== 136'b0) begin errors++; $display("FAIL rm_cleared got %h exp 0", {refill_way_o, refill_idx_o, refill_data_o}); end
    mem_resp_valid_i = 1'b1; mem_resp_data_i = D2;
    tick();
    mem_resp_valid_i = 1'b0;
    #1;
    checks++; if ({refill_we_o, refill_done_o, refill_err_o, miss_ready_o} !== 4'b0001) begin errors++; $display("FAIL rm_resp_ignored got %b exp 0001", {refill_we_o, refill_done_o, refill_err_o, miss_ready_o}); end
  endtask
  initial begin
    rst_i = 1'b1; flush_i = 1'b0; miss_valid_i = 1'b0; miss_idx_i = '0; way_valid_i = '0; lfsr_way_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0; mem_resp_err_i = 1'b0;
    test_reset();
    test_latency();
    test_lfsr_all_valid();
    test_error();
    test_flush_wait();
    test_flush_req_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
